// File: rtl/sddt_pkg.sv
// Shared SDDT constants for the read-data path.
//   RDATA_WIDTH   : DRAM read-beat / AXI-Stream data width in bits
//   RKEEP_WIDTH   : matching byte-enable width
//   CFG_CNT_WIDTH : width of beat-count and timeout configuration fields
package sddt_pkg;

  localparam int RDATA_WIDTH   = 512;
  localparam int RKEEP_WIDTH   = RDATA_WIDTH / 8;
  localparam int CFG_CNT_WIDTH = 16;

endpackage

// File: rtl/rdata_framer.sv
// rdata_framer: turns the raw read-beat stream from the core's read FIFO into
// AXI-Stream packets for the S2MM DMA. A packet closes on a programmed beat
// count, after an idle timeout, or on an explicit flush pulse.
//
// Ports
//   axi_aclk, axi_aresetn     : clock, asynchronous active-low reset
//   s_rdata_tdata/tvalid/tready : incoming beats from the core
//   m_axis_rdata_*            : framed stream (tkeep all-ones when valid)
//   cfg_pkt_beats             : beats per packet, 0 behaves as 1
//   cfg_timeout               : idle cycles before a partial packet closes, 0 = off
//   flush                     : one-cycle pulse closing the current partial packet
//   pkt_count                 : number of tlast handshakes, wraps at 2^32
//   busy                      : beat held, output valid, or packet in progress
module rdata_framer
  import sddt_pkg::*;
#(
  parameter int DATA_WIDTH = RDATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = CFG_CNT_WIDTH
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic [DATA_WIDTH-1:0] s_rdata_tdata,
  input  logic                  s_rdata_tvalid,
  output logic                  s_rdata_tready,
  output logic [DATA_WIDTH-1:0] m_axis_rdata_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_rdata_tkeep,
  output logic                  m_axis_rdata_tlast,
  output logic                  m_axis_rdata_tvalid,
  input  logic                  m_axis_rdata_tready,
  input  logic [CNT_WIDTH-1:0]  cfg_pkt_beats,
  input  logic [CNT_WIDTH-1:0]  cfg_timeout,
  input  logic                  flush,
  output logic [31:0]           pkt_count,
  output logic                  busy
);

  function automatic logic [CNT_WIDTH-1:0] norm_len(input logic [CNT_WIDTH-1:0] beats);
    norm_len = (beats == '0) ? CNT_WIDTH'(1) : beats;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic                  hold_vld;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  out_vld;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic [CNT_WIDTH-1:0]  len_lat;
  logic [CNT_WIDTH-1:0]  idle_cnt;
  logic                  flush_pend;
  logic [31:0]           pkt_cnt;

  logic                  out_free;
  logic [CNT_WIDTH-1:0]  cur_len;
  logic                  at_len;
  logic                  timeout;
  logic                  move;
  logic                  move_last;
  logic                  in_hs;
  logic                  empty;

  always_comb begin
    out_free  = !out_vld || m_axis_rdata_tready;
    // The first beat of a packet sees the live configuration; later beats
    // use the value latched when that first beat left hold.
    cur_len   = (beat_cnt == '0) ? norm_len(cfg_pkt_beats) : len_lat;
    at_len    = (beat_cnt == cur_len - CNT_WIDTH'(1));
    timeout   = (cfg_timeout != '0) && (idle_cnt >= cfg_timeout);
    move      = hold_vld && out_free &&
                (s_rdata_tvalid || at_len || timeout || flush_pend);
    // A following beat proves the held one is not the end of the packet,
    // so it overrides timeout and flush.
    move_last = at_len || (!s_rdata_tvalid && (timeout || flush_pend));
    s_rdata_tready = !hold_vld || move;
    in_hs     = s_rdata_tvalid && s_rdata_tready;
    empty     = !hold_vld && (beat_cnt == '0);
  end

  // Stage 1: hold register, tlast still undecided
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (in_hs) begin
      hold_vld  <= 1'b1;
      hold_data <= s_rdata_tdata;
    end else if (move) begin
      hold_vld  <= 1'b0;
    end
  end

  // Stage 2: output register, stable while stalled
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      out_keep <= '0;
    end else if (move) begin
      out_vld  <= 1'b1;
      out_last <= move_last;
      out_data <= hold_data;
      out_keep <= '1;
    end else if (m_axis_rdata_tready) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      beat_cnt   <= '0;
      len_lat    <= CNT_WIDTH'(1);
      idle_cnt   <= '0;
      flush_pend <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      if (move) begin
        beat_cnt <= move_last ? '0 : beat_cnt + CNT_WIDTH'(1);
        if (beat_cnt == '0) len_lat <= norm_len(cfg_pkt_beats);
      end

      if (in_hs || move)
        idle_cnt <= '0;
      else if (hold_vld && !s_rdata_tvalid)
        idle_cnt <= sat_inc(idle_cnt);

      // Flushing an empty framer is dropped rather than left armed.
      if (move && move_last)
        flush_pend <= 1'b0;
      else if (flush && !empty)
        flush_pend <= 1'b1;

      if (out_vld && m_axis_rdata_tready && out_last)
        pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  assign m_axis_rdata_tdata  = out_data;
  assign m_axis_rdata_tkeep  = out_keep;
  assign m_axis_rdata_tlast  = out_last;
  assign m_axis_rdata_tvalid = out_vld;
  assign pkt_count           = pkt_cnt;
  assign busy                = hold_vld || out_vld || (beat_cnt != '0);

endmodule

// File: tb/tb_rdata_framer.sv
// Bench for rdata_framer: randomized beats checked against a packet-level
// reference model (position in packet, idle gaps between acceptances).
module tb_rdata_framer;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [CW-1:0] cfg_pkt_beats;
  logic [CW-1:0] cfg_timeout;
  logic          flush;
  logic [31:0]   pkt_count;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } out_t;

  out_t          out_q[$];
  int            in_cyc_q[$];
  logic [DW-1:0] stim[$];
  bit            exp_last[$];
  out_t          mon_e;

  rdata_framer dut (
    .axi_aclk            (clk),
    .axi_aresetn         (rst_n),
    .s_rdata_tdata       (s_tdata),
    .s_rdata_tvalid      (s_tvalid),
    .s_rdata_tready      (s_tready),
    .m_axis_rdata_tdata  (m_tdata),
    .m_axis_rdata_tkeep  (m_tkeep),
    .m_axis_rdata_tlast  (m_tlast),
    .m_axis_rdata_tvalid (m_tvalid),
    .m_axis_rdata_tready (m_tready),
    .cfg_pkt_beats       (cfg_pkt_beats),
    .cfg_timeout         (cfg_timeout),
    .flush               (flush),
    .pkt_count           (pkt_count),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are recorded mid-cycle; they complete at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        mon_e.data = m_tdata;
        mon_e.last = m_tlast;
        mon_e.cyc  = cyc;
        out_q.push_back(mon_e);
      end
      if (s_tvalid && s_tready) in_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Packet model with tready held high: a beat closes its packet when it is
  // the len-th beat, or (timeout on) when no beat follows within tmo idle
  // cycles of it entering hold.
  function automatic void model_last(input int len, input int tmo);
    int pos  = 0;
    int leff = (len == 0) ? 1 : len;
    bit l;
    exp_last.delete();
    for (int i = 0; i < in_cyc_q.size(); i++) begin
      l = (pos == leff - 1);
      if (tmo != 0 && (i == in_cyc_q.size() - 1 || in_cyc_q[i+1] > in_cyc_q[i] + 1 + tmo))
        l = 1'b1;
      exp_last.push_back(l);
      pos = l ? 0 : pos + 1;
    end
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    flush    = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_q.delete();
    in_cyc_q.delete();
    stim.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic fl);
    int guard = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    flush    = fl;
    @(negedge clk);
    while (!s_tready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_tready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: s_rdata_tready got 0 want 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (out_q.size() < n) begin
      n_fail++;
      $display("FAIL out_count_wait: got %0d beats want %0d", out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 7;
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_s_tready: got %b want 1", s_tready); end
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    if (m_tlast !== 1'b0)  begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    if (m_tdata !== '0)    begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    if (m_tkeep !== '0)    begin n_fail++; $display("FAIL reset_tkeep: got %h want 0", m_tkeep); end
    if (pkt_count !== 32'd0) begin n_fail++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_fixed_len();
    do_reset();
    cfg_pkt_beats = 16'd4;
    cfg_timeout   = 16'd0;
    for (int i = 0; i < 12; i++) stim.push_back(rnd512());
    for (int i = 0; i < 12; i++) send_beat(stim[i], 1'b0);
    wait_out(12, 100);
    idle(2);
    model_last(4, 0);
    for (int i = 0; i < 12 && i < out_q.size(); i++) begin
      n_cmp += 3;
      if (out_q[i].data !== stim[i]) begin n_fail++; $display("FAIL fixed_data[%0d]: got %h want %h", i, out_q[i].data, stim[i]); end
      if (out_q[i].last !== exp_last[i]) begin n_fail++; $display("FAIL fixed_last[%0d]: got %b want %b", i, out_q[i].last, exp_last[i]); end
      if (out_q[i].cyc !== out_q[0].cyc + i) begin n_fail++; $display("FAIL fixed_bubble[%0d]: got cycle %0d want %0d", i, out_q[i].cyc, out_q[0].cyc + i); end
    end
    n_cmp += 3;
    if (out_q.size() > 0 && in_cyc_q.size() > 0 && out_q[0].cyc - in_cyc_q[0] != 2) begin
      n_fail++; $display("FAIL fixed_latency: got %0d want 2", out_q[0].cyc - in_cyc_q[0]);
    end
    if (pkt_count !== 32'd3) begin n_fail++; $display("FAIL fixed_pkt_count: got %0d want 3", pkt_count); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fixed_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    cfg_pkt_beats = 16'd8;
    cfg_timeout   = 16'd10;
    for (int i = 0; i < 11; i++) stim.push_back(rnd512());
    for (int i = 0; i < 3; i++) send_beat(stim[i], 1'b0);
    idle(30);
    wait_out(3, 50);
    n_cmp += 3;
    if (out_q.size() >= 3 && in_cyc_q.size() >= 3 && out_q[2].cyc - in_cyc_q[2] != 12) begin
      n_fail++; $display("FAIL timeout_latency: got %0d want 12", out_q[2].cyc - in_cyc_q[2]);
    end
    if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL timeout_pkt_count: got %0d want 1", pkt_count); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
    for (int i = 3; i < 11; i++) send_beat(stim[i], 1'b0);
    idle(40);
    wait_out(11, 20);
    model_last(8, 10);
    for (int i = 0; i < 11 && i < out_q.size(); i++) begin
      n_cmp += 2;
      if (out_q[i].data !== stim[i]) begin n_fail++; $display("FAIL timeout_data[%0d]: got %h want %h", i, out_q[i].data, stim[i]); end
      if (out_q[i].last !== exp_last[i]) begin n_fail++; $display("FAIL timeout_last[%0d]: got %b want %b", i, out_q[i].last, exp_last[i]); end
    end
    n_cmp++;
    if (pkt_count !== 32'd2) begin n_fail++; $display("FAIL timeout_pkt_count2: got %0d want 2", pkt_count); end
  endtask

  task automatic test_len_zero();
    do_reset();
    cfg_pkt_beats = 16'd0;
    cfg_timeout   = 16'd0;
    for (int i = 0; i < 10; i++) stim.push_back(rnd512());
    for (int i = 0; i < 10; i++) begin
      send_beat(stim[i], 1'b0);
      idle($urandom_range(0, 3));
    end
    wait_out(10, 50);
    idle(2);
    model_last(0, 0);
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      n_cmp += 2;
      if (out_q[i].data !== stim[i]) begin n_fail++; $display("FAIL len0_data[%0d]: got %h want %h", i, out_q[i].data, stim[i]); end
      if (out_q[i].last !== exp_last[i]) begin n_fail++; $display("FAIL len0_last[%0d]: got %b want %b", i, out_q[i].last, exp_last[i]); end
    end
    n_cmp++;
    if (pkt_count !== 32'd10) begin n_fail++; $display("FAIL len0_pkt_count: got %0d want 10", pkt_count); end
  endtask

  task automatic test_backpressure();
    int            sent = 0;
    bit            stalled = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    do_reset();
    cfg_pkt_beats = 16'd5;
    cfg_timeout   = 16'd0;
    for (int i = 0; i < 100; i++) stim.push_back(rnd512());
    for (int k = 0; k < 3000 && out_q.size() < 100; k++) begin
      s_tvalid = (sent < 100);
      s_tdata  = (sent < 100) ? stim[sent] : '0;
      m_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        n_cmp++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
          n_fail++;
          $display("FAIL bp_hold: got vld=%b last=%b want vld=1 last=%b (data equal=%b)",
                   m_tvalid, m_tlast, prev_last, m_tdata === prev_data);
        end
      end
      stalled   = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
      if (s_tvalid && s_tready) sent++;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    wait_out(100, 10);
    idle(2);
    model_last(5, 0);
    for (int i = 0; i < 100 && i < out_q.size(); i++) begin
      n_cmp += 2;
      if (out_q[i].data !== stim[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, out_q[i].data, stim[i]); end
      if (out_q[i].last !== exp_last[i]) begin n_fail++; $display("FAIL bp_last[%0d]: got %b want %b", i, out_q[i].last, exp_last[i]); end
    end
    n_cmp++;
    if (pkt_count !== 32'd20) begin n_fail++; $display("FAIL bp_pkt_count: got %0d want 20", pkt_count); end
  endtask

  task automatic test_flush();
    do_reset();
    cfg_pkt_beats = 16'd16;
    cfg_timeout   = 16'd0;
    for (int i = 0; i < 5; i++) stim.push_back(rnd512());
    send_beat(stim[0], 1'b0);
    send_beat(stim[1], 1'b0);
    idle(3);
    send_beat(stim[2], 1'b1);
    idle(5);
    wait_out(3, 20);
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      n_cmp += 2;
      if (out_q[i].data !== stim[i]) begin n_fail++; $display("FAIL flush_data[%0d]: got %h want %h", i, out_q[i].data, stim[i]); end
      if (out_q[i].last !== (i == 2)) begin n_fail++; $display("FAIL flush_last[%0d]: got %b want %b", i, out_q[i].last, i == 2); end
    end
    n_cmp += 2;
    if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL flush_pkt_count: got %0d want 1", pkt_count); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    // flush on an empty framer must leave nothing armed
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(3);
    send_beat(stim[3], 1'b0);
    send_beat(stim[4], 1'b0);
    idle(5);
    n_cmp += 3;
    if (out_q.size() != 4) begin n_fail++; $display("FAIL flush_empty_count: got %0d want 4", out_q.size()); end
    if (out_q.size() >= 4 && out_q[3].last !== 1'b0) begin n_fail++; $display("FAIL flush_empty_last: got %b want 0", out_q[3].last); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_held_busy: got %b want 1", busy); end
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(5);
    n_cmp += 3;
    if (out_q.size() != 5) begin
      n_fail++; $display("FAIL flush_close_count: got %0d want 5", out_q.size());
    end else if (out_q[4].last !== 1'b1 || out_q[4].data !== stim[4]) begin
      n_fail++; $display("FAIL flush_close_beat: got last=%b want 1 (data equal=%b)", out_q[4].last, out_q[4].data === stim[4]);
    end
    if (pkt_count !== 32'd2) begin n_fail++; $display("FAIL flush_pkt_count2: got %0d want 2", pkt_count); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_pkt_beats = 16'd4;
    cfg_timeout   = 16'd0;
    send_beat(rnd512(), 1'b0);
    send_beat(rnd512(), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid: got %b want 0", m_tvalid); end
    if (m_tlast !== 1'b0)  begin n_fail++; $display("FAIL midrst_tlast: got %b want 0", m_tlast); end
    if (m_tdata !== '0)    begin n_fail++; $display("FAIL midrst_tdata: got %h want 0", m_tdata); end
    if (m_tkeep !== '0)    begin n_fail++; $display("FAIL midrst_tkeep: got %h want 0", m_tkeep); end
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL midrst_s_tready: got %b want 1", s_tready); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_q.delete();
    in_cyc_q.delete();
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(rnd512());
    for (int i = 0; i < 4; i++) send_beat(stim[i], 1'b0);
    idle(5);
    model_last(4, 0);
    n_cmp += 2;
    if (out_q.size() != 4) begin n_fail++; $display("FAIL midrst_count: got %0d want 4", out_q.size()); end
    if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL midrst_pkt_count: got %0d want 1", pkt_count); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_cmp += 2;
      if (out_q[i].data !== stim[i]) begin n_fail++; $display("FAIL midrst_data[%0d]: got %h want %h", i, out_q[i].data, stim[i]); end
      if (out_q[i].last !== exp_last[i]) begin n_fail++; $display("FAIL midrst_last[%0d]: got %b want %b", i, out_q[i].last, exp_last[i]); end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    s_tvalid      = 1'b0;
    s_tdata       = '0;
    flush         = 1'b0;
    m_tready      = 1'b1;
    cfg_pkt_beats = 16'd4;
    cfg_timeout   = 16'd0;
    test_reset();
    test_fixed_len();
    test_timeout();
    test_len_zero();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
